// File: rtl/sample_window_stats.sv
// Windowed sum/count (and optional min/max) over 2**WIN_LOG2 unsigned samples.
// Min/max tracking is compiled only when SAMPLE_WINDOW_STATS_MINMAX_EN is defined.
module sample_window_stats #(
    parameter int unsigned DATA_W   = 22,
    parameter int unsigned WIN_LOG2 = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W+WIN_LOG2-1:0] out_sum,
    output logic [DATA_W-1:0]          out_min,
    output logic [DATA_W-1:0]          out_max,
    output logic [WIN_LOG2:0]          out_count
);

    localparam int unsigned SumW = DATA_W + WIN_LOG2;
    localparam int unsigned CntW = WIN_LOG2 + 1;
    localparam logic [CntW-1:0] WinLen = {1'b1, {WIN_LOG2{1'b0}}};

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e          state_q, state_d;
    logic [SumW-1:0] sum_q, sum_d, acc_sum, out_sum_q, out_sum_d;
    logic [CntW-1:0] count_q, count_d, acc_count, out_count_q, out_count_d;
    logic            accept;
    logic            emit;

    assign in_ready  = (state_q == StAccum) && !rst;
    assign out_valid = (state_q == StHold);
    assign accept    = in_valid && in_ready;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

    // Running totals including this cycle's sample, so a flush alongside a sample includes it.
    always_comb begin
        acc_sum   = sum_q;
        acc_count = count_q;
        if (accept) begin
            acc_sum   = sum_q + SumW'(in_data);
            acc_count = count_q + CntW'(1);
        end
    end

    assign emit = (state_q == StAccum) &&
                  ((acc_count == WinLen) || (flush && (acc_count != '0)));

    always_comb begin
        state_d     = state_q;
        sum_d       = acc_sum;
        count_d     = acc_count;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        case (state_q)
            StAccum: begin
                if (emit) begin
                    out_sum_d   = acc_sum;
                    out_count_d = acc_count;
                    sum_d       = '0;
                    count_d     = '0;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAccum;
            sum_q       <= '0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

`ifdef SAMPLE_WINDOW_STATS_MINMAX_EN
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [DATA_W-1:0] acc_min, acc_max;
    logic [DATA_W-1:0] out_min_q, out_min_d, out_max_q, out_max_d;

    // The first sample of a window loads both extremes directly.
    always_comb begin
        acc_min = min_q;
        acc_max = max_q;
        if (accept) begin
            if (count_q == '0) begin
                acc_min = in_data;
                acc_max = in_data;
            end else begin
                if (in_data < min_q) acc_min = in_data;
                if (in_data > max_q) acc_max = in_data;
            end
        end
    end

    always_comb begin
        min_d     = acc_min;
        max_d     = acc_max;
        out_min_d = out_min_q;
        out_max_d = out_max_q;
        if (emit) begin
            out_min_d = acc_min;
            out_max_d = acc_max;
            min_d     = '0;
            max_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q     <= '0;
            max_q     <= '0;
            out_min_q <= '0;
            out_max_q <= '0;
        end else begin
            min_q     <= min_d;
            max_q     <= max_d;
            out_min_q <= out_min_d;
            out_max_q <= out_max_d;
        end
    end

    assign out_min = out_min_q;
    assign out_max = out_max_q;
`else
    assign out_min = '0;
    assign out_max = '0;
`endif

endmodule

// File: tb/tb_sample_window_stats.sv
// Directed bench for sample_window_stats: table of windows plus hand-written
// reset/backpressure/flush corner sequences.
module tb_sample_window_stats;

    localparam int unsigned DATA_W   = 22;
    localparam int unsigned WIN_LOG2 = 3;

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       in_ready;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W+WIN_LOG2-1:0] out_sum;
    logic [DATA_W-1:0]          out_min;
    logic [DATA_W-1:0]          out_max;
    logic [WIN_LOG2:0]          out_count;

    sample_window_stats #(
        .DATA_W  (DATA_W),
        .WIN_LOG2(WIN_LOG2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_min  (out_min),
        .out_max  (out_max),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 = full window, 1 = flush on the cycle after the last sample,
    //       2 = flush together with the last sample
    typedef struct packed {
        logic [7:0][DATA_W-1:0] s;
        logic [3:0]             n;
        logic [1:0]             mode;
        logic [24:0]            sum;
        logic [DATA_W-1:0]      mn;
        logic [DATA_W-1:0]      mx;
        logic [3:0]             cnt;
    } vec_t;

    vec_t vecs [6];
    int   total;
    int   bad;

`ifdef SAMPLE_WINDOW_STATS_MINMAX_EN
    localparam bit MinMax = 1'b1;
`else
    localparam bit MinMax = 1'b0;
`endif

    function automatic vec_t mk(input logic [DATA_W-1:0] a0, a1, a2, a3, a4, a5, a6, a7,
                                input int n, input int mode, input int sum,
                                input int mn, input int mx);
        vec_t v;
        v.s    = {a7, a6, a5, a4, a3, a2, a1, a0};
        v.n    = 4'(n);
        v.mode = 2'(mode);
        v.sum  = 25'(sum);
        v.mn   = MinMax ? DATA_W'(mn) : '0;
        v.mx   = MinMax ? DATA_W'(mx) : '0;
        v.cnt  = 4'(n);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [DATA_W-1:0] d, input logic fl);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, " out_sum"}, 64'(out_sum), 64'(v.sum));
        chk({tag, " out_min"}, 64'(out_min), 64'(v.mn));
        chk({tag, " out_max"}, 64'(out_max), 64'(v.mx));
        chk({tag, " out_count"}, 64'(out_count), 64'(v.cnt));
    endtask

    // Applies one table window with out_ready high.
    task automatic run_vec(input int idx);
        vec_t  v;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("vec%0d", idx);
        out_ready = 1'b1;
        for (int i = 0; i < int'(v.n); i++) begin
            feed(v.s[i], (v.mode == 2'd2) && (i == int'(v.n) - 1));
        end
        if (v.mode == 2'd1) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        check_result(tag, v);
        tick();
        chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hv;
        total = 0;
        bad   = 0;
        vecs[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 8, 0, 36, 1, 8);
        vecs[1] = mk(5, 100, 7, 0, 0, 0, 0, 0, 3, 1, 112, 5, 100);
        vecs[2] = mk(22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF,
                     22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF,
                     8, 0, 33554424, 4194303, 4194303);
        vecs[3] = mk(9, 3, 0, 0, 0, 0, 0, 0, 2, 2, 12, 3, 9);
        vecs[4] = mk(42, 0, 0, 0, 0, 0, 0, 0, 1, 1, 42, 42, 42);
        vecs[5] = mk(1000, 20, 300, 4, 50000, 6, 70, 8, 8, 0, 51408, 4, 50000);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_sum", 64'(out_sum), 64'd0);
        chk("reset out_count", 64'(out_count), 64'd0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);

        // Flush on an empty window must not produce a result.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty flush out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("empty flush out_valid later", 64'(out_valid), 64'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec(k);
        end

        // Backpressure: result held for 5 cycles, no sample accepted meanwhile.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            feed(DATA_W'(11 + i), 1'b0);
        end
        in_valid = 1'b1;
        in_data  = 22'd999;
        for (int c = 0; c < 5; c++) begin
            chk("hold out_valid", 64'(out_valid), 64'd1);
            chk("hold in_ready", 64'(in_ready), 64'd0);
            chk("hold out_sum", 64'(out_sum), 64'd116);
            chk("hold out_count", 64'(out_count), 64'd8);
            chk("hold out_max", 64'(out_max), MinMax ? 64'd18 : 64'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release out_valid", 64'(out_valid), 64'd0);
        chk("release in_ready", 64'(in_ready), 64'd1);
        run_vec(0);

        // Reset mid-window discards the partial samples.
        for (int i = 0; i < 4; i++) begin
            feed(DATA_W'(50 + 10 * i), 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("mid rst in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        run_vec(0);

        // Reset while presenting a result drops out_valid without out_ready.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            feed(DATA_W'(i + 1), 1'b0);
        end
        chk("pre-rst hold out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("rst in hold out_valid", 64'(out_valid), 64'd0);
        chk("rst in hold out_sum", 64'(out_sum), 64'd0);
        chk("rst in hold out_count", 64'(out_count), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        hv = vecs[4];
        run_vec(4);
        chk("after rst-in-hold sum", 64'(out_sum), 64'(hv.sum));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
